// File: rtl/pixel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pixel_scan_ctrl
// Description : Frame scan sequencer. Walks the H_RES x V_RES pixel grid and
//               issues one x/y coordinate per valid/ready transfer, with
//               sof/eol markers and a frame_done pulse.
//               Optional macro SCAN_CONTINUOUS_EN selects free-running scan.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_scan_ctrl #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 10
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic               abort,
    input  logic               stop,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               sof,
    output logic               eol,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               frame_done_q, frame_done_d;
    logic               w_repeat;

`ifdef SCAN_CONTINUOUS_EN
    assign w_repeat = ~stop;
`else
    // Single-shot build: stop has no effect.
    logic w_unused_stop;
    assign w_unused_stop = stop;
    assign w_repeat      = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (x_q != X_LAST) begin
                            x_d = x_q + COORD_W'(1);
                        end else if (y_q != Y_LAST) begin
                            x_d = '0;
                            y_d = y_q + COORD_W'(1);
                        end else begin
                            // Last pixel of the frame accepted.
                            x_d          = '0;
                            y_d          = '0;
                            frame_done_d = 1'b1;
                            state_d      = w_repeat ? RUN : IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign x          = x_q;
    assign y          = y_q;
    assign frame_done = frame_done_q;
    assign sof        = out_valid && (x_q == '0) && (y_q == '0);
    assign eol        = out_valid && (x_q == X_LAST);

endmodule
`default_nettype wire

// File: tb/tb_pixel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_scan_ctrl
// Description : Scoreboard bench for pixel_scan_ctrl using a pixel-index model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_scan_ctrl;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int N  = H * V;
    localparam int CW = 3;

    logic          aclk;
    logic          aresetn;
    logic          start;
    logic          abort;
    logic          stop;
    logic          out_ready;
    logic          out_valid;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          eol;
    logic          busy;
    logic          frame_done;

    pixel_scan_ctrl #(
        .H_RES   (H),
        .V_RES   (V),
        .COORD_W (CW)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .abort      (abort),
        .stop       (stop),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .x          (x),
        .y          (y),
        .sof        (sof),
        .eol        (eol),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        bit v;
        bit fd;
        bit sof;
        bit eol;
        int x;
        int y;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_run    = 0;
    int   m_idx    = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic exp_t mk(input bit run, input int idx, input bit fd);
        exp_t e;
        e.v   = run;
        e.fd  = fd;
        e.x   = idx % H;
        e.y   = idx / H;
        e.sof = run && (idx == 0);
        e.eol = run && ((idx % H) == H - 1);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs and push the expected outputs after the next edge.
    task automatic cycle(input bit st, input bit ab, input bit sp, input bit rd);
        bit fd;
        @(posedge aclk);
        #1;
        aresetn   = 1'b1;
        start     = st;
        abort     = ab;
        stop      = sp;
        out_ready = rd;
        fd = 1'b0;
        if (ab) begin
            m_run = 1'b0;
            m_idx = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1'b1;
                m_idx = 0;
            end
        end else if (rd) begin
            if (m_idx == N - 1) begin
                fd    = 1'b1;
                m_idx = 0;
`ifdef SCAN_CONTINUOUS_EN
                m_run = !sp;
`else
                m_run = 1'b0;
`endif
            end else begin
                m_idx++;
            end
        end
        exp_q.push_back(mk(m_run, m_idx, fd));
    endtask

    // Reset takes effect immediately, so the in-flight expectation is replaced too.
    task automatic rst_cycle();
        @(posedge aclk);
        #1;
        aresetn   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;
        m_run     = 1'b0;
        m_idx     = 0;
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = mk(1'b0, 0, 1'b0);
        exp_q.push_back(mk(1'b0, 0, 1'b0));
    endtask

    task automatic run_until(input int target);
        for (int k = 0; k < 4 * N && !(m_run && m_idx == target); k++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge aclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid",  int'(out_valid),  int'(e.v));
                chk("busy",       int'(busy),       int'(e.v));
                chk("frame_done", int'(frame_done), int'(e.fd));
                chk("x",          int'(x),          e.x);
                chk("y",          int'(y),          e.y);
                chk("sof",        int'(sof),        int'(e.sof));
                chk("eol",        int'(eol),        int'(e.eol));
            end
        end
    end

    initial begin : stimulus
        aresetn   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;
        exp_q.push_back(mk(1'b0, 0, 1'b0));
        rst_cycle();
        rst_cycle();
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Full frame with ready held high, then re-start on the frame_done cycle.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (N) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (N + 3) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure at (2,1).
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_until(6);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (N) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort together with start at (1,2), then a clean frame.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_until(9);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (N + 2) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset at (3,0); nothing happens until start.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_until(3);
        rst_cycle();
        rst_cycle();
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (N + 2) cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SCAN_CONTINUOUS_EN
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (N + 3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (N + 3) cycle(1'b0, 1'b0, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                rst_cycle();
            end else begin
                cycle($urandom_range(7) == 0, $urandom_range(39) == 0,
                      $urandom_range(3) == 0, $urandom_range(3) != 0);
            end
        end

        repeat (3) @(negedge aclk);
        chk("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
